// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

   typedef enum logic [1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int          MULDIV_ITERS = 32;
   localparam logic [31:0] DIVZERO_LO   = 32'hFFFFFFFF;

   // Both divide opcodes share the upper opcode bit.
   function automatic logic is_div(input op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// Decoder-side bundle for the multiply/divide sequencer: request, MT writes and HI/LO readback.
interface muldiv_seq_ctrl_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             start;
   op_t              op;
   logic [WIDTH-1:0] rs_content;
   logic [WIDTH-1:0] rt_content;
   logic             mthi_we;
   logic             mtlo_we;
   logic [WIDTH-1:0] mt_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_content, rt_content, mthi_we, mtlo_we, mt_data,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs_content, rt_content, mthi_we, mtlo_we, mt_data,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_sign_fix.sv
// Final correction stage: turns the unsigned magnitude result into the architectural HI/LO pair.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_t              op,
   input  logic             neg_q,
   input  logic             neg_r,
   input  logic             div_zero,
   input  logic [2*WIDTH-1:0] raw,
   input  logic [WIDTH-1:0] rs_orig,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quot;

   // Select product or remainder/quotient and apply the recorded sign corrections.
   always_comb begin
      prod = raw;
      rem  = raw[2*WIDTH-1:WIDTH];
      quot = raw[WIDTH-1:0];
      hi   = rem;
      lo   = quot;
      if (is_div(op)) begin
         if (div_zero) begin
            hi = rs_orig;
            lo = WIDTH'(DIVZERO_LO);
         end else begin
            hi = neg_r ? -rem  : rem;
            lo = neg_q ? -quot : quot;
         end
      end else begin
         if (op == MULT && neg_q) begin
            prod = -raw;
         end
         hi = prod[2*WIDTH-1:WIDTH];
         lo = prod[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Radix-2 shift-add multiply or restoring divide on magnitudes, then one sign-fix cycle.
module muldiv_seq_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = MULDIV_ITERS
) (
   input logic              clk,
   input logic              rst_n,
   muldiv_seq_ctrl_if.slave bus
);

   localparam int CW = $clog2(ITERS);
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

   state_t             state;
   op_t                op_r;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   rs_orig;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CW-1:0]      count;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;
   logic               done_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic [WIDTH-1:0]   hi_fix;
   logic [WIDTH-1:0]   lo_fix;

   logic               signed_op;
   logic               mt_any;
   logic [WIDTH-1:0]   mag_rs;
   logic [WIDTH-1:0]   mag_rt;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   sub;
   logic               fits;

   // Operand magnitudes taken at start; 0x80000000 stays 0x80000000 as unsigned.
   always_comb begin
      signed_op = (bus.op == MULT) || (bus.op == DIV);
      mt_any    = bus.mthi_we | bus.mtlo_we;
      mag_rs    = (signed_op && bus.rs_content[WIDTH-1]) ? -bus.rs_content : bus.rs_content;
      mag_rt    = (signed_op && bus.rt_content[WIDTH-1]) ? -bus.rt_content : bus.rt_content;
   end

   // One multiply or divide iteration; the remainder may carry one extra bit after the shift.
   always_comb begin
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      rem_sh  = acc[2*WIDTH-1:WIDTH-1];
      sub     = rem_sh[WIDTH-1:0] - operand;
      fits    = rem_sh[WIDTH] || (rem_sh[WIDTH-1:0] >= operand);
      if (is_div(op_r)) begin
         if (fits) begin
            acc_next = {sub, acc[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // Sequencer: latch operands, iterate, fix up; any MT write aborts an operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_r     <= MULT;
         operand  <= '0;
         rs_orig  <= '0;
         acc      <= '0;
         count    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= (state == FIX) && !mt_any;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_r     <= bus.op;
                  neg_q    <= signed_op & (bus.rs_content[WIDTH-1] ^ bus.rt_content[WIDTH-1]);
                  neg_r    <= signed_op & bus.rs_content[WIDTH-1];
                  div_zero <= is_div(bus.op) && (bus.rt_content == '0);
                  rs_orig  <= bus.rs_content;
                  count    <= '0;
                  if (is_div(bus.op)) begin
                     operand <= mag_rt;
                     acc     <= {{WIDTH{1'b0}}, mag_rs};
                  end else begin
                     operand <= mag_rs;
                     acc     <= {{WIDTH{1'b0}}, mag_rt};
                  end
                  state <= CALC;
               end
            end
            CALC: begin
               if (mt_any) begin
                  state <= IDLE;
               end else begin
                  acc   <= acc_next;
                  count <= count + 1'b1;
                  if (count == LAST) begin
                     state <= FIX;
                  end
               end
            end
            FIX: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // HI/LO change only on reset, an MT write, or a completed fix-up cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (state == FIX && !mt_any) begin
         hi_r <= hi_fix;
         lo_r <= lo_fix;
      end else begin
         if (bus.mthi_we) begin
            hi_r <= bus.mt_data;
         end
         if (bus.mtlo_we) begin
            lo_r <= bus.mt_data;
         end
      end
   end

   muldiv_sign_fix #(
      .WIDTH (WIDTH)
   ) u_sign_fix (
      .op       (op_r),
      .neg_q    (neg_q),
      .neg_r    (neg_r),
      .div_zero (div_zero),
      .raw      (acc),
      .rs_orig  (rs_orig),
      .hi       (hi_fix),
      .lo       (lo_fix)
   );

   assign bus.busy = (state != IDLE);
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed self-checking bench for muldiv_seq_ctrl with hand-computed HI/LO results.
module tb_muldiv_seq_ctrl;
   import muldiv_pkg::*;

   logic clk;
   logic rst_n;
   int   passCount;
   int   checkCount;
   int   doneSeen;

   muldiv_seq_ctrl_if #(.WIDTH(32)) bus();

   muldiv_seq_ctrl #(.WIDTH(32), .ITERS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock; inputs change and outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present one request for a single cycle; returns at the falling edge after the start edge.
   task automatic applyStimulus(input op_t o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.op         = o;
      bus.rs_content = a;
      bus.rt_content = b;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
   endtask

   task automatic runOp(input string tag, input op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expHi, input logic [31:0] expLo);
      applyStimulus(o, a, b);
      checkOutput({tag, " busy after start"}, bus.busy, 1);
      repeat (32) @(negedge clk);
      checkOutput({tag, " busy before fix"}, bus.busy, 1);
      checkOutput({tag, " done before fix"}, bus.done, 0);
      @(negedge clk);
      checkOutput({tag, " busy after fix"}, bus.busy, 0);
      checkOutput({tag, " done pulse"}, bus.done, 1);
      checkOutput({tag, " hi"}, bus.hi, expHi);
      checkOutput({tag, " lo"}, bus.lo, expLo);
      @(negedge clk);
      checkOutput({tag, " done clears"}, bus.done, 0);
   endtask

   initial begin
      passCount      = 0;
      checkCount     = 0;
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.op         = MULT;
      bus.rs_content = '0;
      bus.rt_content = '0;
      bus.mthi_we    = 1'b0;
      bus.mtlo_we    = 1'b0;
      bus.mt_data    = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset busy", bus.busy, 0);
      checkOutput("reset done", bus.done, 0);
      checkOutput("reset hi", bus.hi, 0);
      checkOutput("reset lo", bus.lo, 0);
      rst_n = 1'b1;

      runOp("multu max",     MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      runOp("multu carry",   MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
      runOp("mult neg",      MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
      runOp("mult minmin",   MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      runOp("div neg dvd",   DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      runOp("div neg dvs",   DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      runOp("divu",          DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
      runOp("divu by zero",  DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
      runOp("div by zero",   DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
      runOp("div overflow",  DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      // A second start while busy must be dropped; the first result still lands on time.
      applyStimulus(MULTU, 32'd5, 32'd6);
      repeat (2) @(negedge clk);
      bus.op         = DIVU;
      bus.rs_content = 32'd100;
      bus.rt_content = 32'd7;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
      repeat (29) @(negedge clk);
      checkOutput("ignored start busy", bus.busy, 1);
      @(negedge clk);
      checkOutput("ignored start done", bus.done, 1);
      checkOutput("ignored start busy end", bus.busy, 0);
      checkOutput("ignored start hi", bus.hi, 32'd0);
      checkOutput("ignored start lo", bus.lo, 32'd30);
      repeat (4) @(negedge clk);
      checkOutput("ignored start stays idle", bus.busy, 0);

      // MTHI while idle lands on the next edge and leaves LO alone.
      bus.mthi_we = 1'b1;
      bus.mt_data = 32'h00001234;
      @(negedge clk);
      bus.mthi_we = 1'b0;
      checkOutput("mthi idle hi", bus.hi, 32'h00001234);
      checkOutput("mthi idle lo", bus.lo, 32'd30);

      // MTLO at the tenth edge of an operation aborts it without a done pulse.
      applyStimulus(MULTU, 32'd5, 32'd6);
      repeat (9) @(negedge clk);
      bus.mtlo_we = 1'b1;
      bus.mt_data = 32'h000000AA;
      @(negedge clk);
      bus.mtlo_we = 1'b0;
      checkOutput("abort lo", bus.lo, 32'h000000AA);
      checkOutput("abort hi", bus.hi, 32'h00001234);
      checkOutput("abort busy", bus.busy, 0);
      checkOutput("abort done", bus.done, 0);
      doneSeen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.done) doneSeen++;
      end
      checkOutput("abort no done", doneSeen, 0);
      checkOutput("abort hi kept", bus.hi, 32'h00001234);
      checkOutput("abort lo kept", bus.lo, 32'h000000AA);

      // Simultaneous MTHI and MTLO write the same data to both.
      bus.mthi_we = 1'b1;
      bus.mtlo_we = 1'b1;
      bus.mt_data = 32'hDEADBEEF;
      @(negedge clk);
      bus.mthi_we = 1'b0;
      bus.mtlo_we = 1'b0;
      checkOutput("mt both hi", bus.hi, 32'hDEADBEEF);
      checkOutput("mt both lo", bus.lo, 32'hDEADBEEF);

      // Reset dropped between clock edges clears everything immediately.
      applyStimulus(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset hi", bus.hi, 0);
      checkOutput("async reset lo", bus.lo, 0);
      checkOutput("async reset busy", bus.busy, 0);
      checkOutput("async reset done", bus.done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Start together with MTHI: the write lands first, then the result overwrites both.
      @(negedge clk);
      bus.op         = MULTU;
      bus.rs_content = 32'd3;
      bus.rt_content = 32'd4;
      bus.start      = 1'b1;
      bus.mthi_we    = 1'b1;
      bus.mt_data    = 32'h00000055;
      @(negedge clk);
      bus.start      = 1'b0;
      bus.mthi_we    = 1'b0;
      checkOutput("start+mthi hi early", bus.hi, 32'h00000055);
      checkOutput("start+mthi busy", bus.busy, 1);
      repeat (33) @(negedge clk);
      checkOutput("start+mthi done", bus.done, 1);
      checkOutput("start+mthi hi", bus.hi, 32'd0);
      checkOutput("start+mthi lo", bus.lo, 32'd12);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
